tnet_rx_deframer: RTL and testbench

- Receive-side packet deframer for one tnet link channel, sitting directly downstream of the Aurora RX AXI-Stream user interface.
- Consumes the 64-bit axi_rx beat stream and assembles 2-beat tnet packets (header + payload), validating the framing of each.
- Buffers good packets in a small FIFO and presents them, with decoded fields, to the qick_net_duplex control logic over a valid/ready handshake.
- Reports framing and overflow faults as sticky flags.

---
 rtl/tnet_rx_deframer.sv | 171 +++++++++++++++++
 tb/tb_tnet_rx_deframer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnet_rx_deframer.sv
// tnet RX deframer: assembles 2-beat tnet packets from the Aurora RX stream, queues good ones in a FIFO.
// Define TNET_RX_STATS_EN to add packet/drop/error statistics counters.
module tnet_rx_deframer #(
  parameter int         FIFO_AW = 2,
  parameter logic [2:0] SYNC_MK = 3'b101
) (
  input  logic        c_clk_i,
  input  logic        c_rst_i,
  input  logic        axi_rx_tvalid_i,
  input  logic [63:0] axi_rx_tdata_i,
  input  logic        axi_rx_tlast_i,
  input  logic [7:0]  my_id_i,
  output logic        pkt_vld_o,
  input  logic        pkt_rdy_i,
  output logic [4:0]  pkt_op_o,
  output logic [7:0]  pkt_dst_o,
  output logic [7:0]  pkt_src_o,
  output logic [7:0]  pkt_hop_o,
  output logic [31:0] pkt_dt1_o,
  output logic [31:0] pkt_dt2_o,
  output logic [31:0] pkt_dt3_o,
  output logic        pkt_mine_o,
  output logic [3:0]  err_o,
  input  logic        err_clr_i
`ifdef TNET_RX_STATS_EN
  ,
  output logic [31:0] rx_pkt_cnt_o,
  output logic [15:0] rx_drop_cnt_o,
  output logic [15:0] rx_err_cnt_o
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, HDR, DISCARD} state_t;

  state_t             state;
  logic [63:0]        hdr_q;
  logic [127:0]       pend_pkt;
  logic               pend_mine;
  logic               push_q;

  // Entry layout: {mine, header[63:0], payload[63:0]}
  logic [128:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [128:0]       head;

  logic               sync_ok;
  logic               set_short;
  logic               set_long;
  logic               set_bad;
  logic               set_ovf;
  logic               cap_pay;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic [3:0]         err_q;

  assign sync_ok   = (axi_rx_tdata_i[63:61] == SYNC_MK);
  assign set_bad   = axi_rx_tvalid_i && (state == IDLE) && !sync_ok;
  assign set_short = axi_rx_tvalid_i && (state == IDLE) && sync_ok && axi_rx_tlast_i;
  assign set_long  = axi_rx_tvalid_i && (state == HDR) && !axi_rx_tlast_i;
  assign cap_pay   = axi_rx_tvalid_i && (state == HDR) && axi_rx_tlast_i;

  assign full      = (count == (FIFO_AW + 1)'(DEPTH));
  assign pkt_vld_o = (count != '0);
  assign pop       = pkt_vld_o && pkt_rdy_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_q && (!full || pop);
  assign set_ovf   = push_q && full && !pop;

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      state     <= IDLE;
      hdr_q     <= '0;
      pend_pkt  <= '0;
      pend_mine <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (axi_rx_tvalid_i) begin
        unique case (state)
          IDLE: begin
            if (!sync_ok) begin
              state <= axi_rx_tlast_i ? IDLE : DISCARD;
            end else if (!axi_rx_tlast_i) begin
              hdr_q <= axi_rx_tdata_i;
              state <= HDR;
            end
          end
          HDR: begin
            if (axi_rx_tlast_i) begin
              // Header is copied alongside the payload so a back-to-back header can reuse hdr_q.
              pend_pkt  <= {hdr_q, axi_rx_tdata_i};
              pend_mine <= (hdr_q[55:48] == my_id_i) || (hdr_q[55:48] == 8'hFF);
              push_q    <= 1'b1;
            end
            state <= IDLE;
            if (!axi_rx_tlast_i) state <= DISCARD;
          end
          DISCARD: begin
            if (axi_rx_tlast_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (push_ok) mem[wr_ptr] <= {pend_mine, pend_pkt};
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A set event in the same cycle as a clear wins.
  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) err_q <= '0;
    else         err_q <= (err_clr_i ? 4'b0000 : err_q) | {set_ovf, set_bad, set_long, set_short};
  end

  assign err_o      = err_q;
  assign head       = pkt_vld_o ? mem[rd_ptr] : '0;
  assign pkt_mine_o = head[128];
  assign pkt_op_o   = head[124:120];
  assign pkt_dst_o  = head[119:112];
  assign pkt_src_o  = head[111:104];
  assign pkt_hop_o  = head[103:96];
  assign pkt_dt1_o  = head[95:64];
  assign pkt_dt2_o  = head[63:32];
  assign pkt_dt3_o  = head[31:0];

`ifdef TNET_RX_STATS_EN
  logic frame_err;
  assign frame_err = set_short || set_long || set_bad;

  // Clears behave like err_o: an event in the clearing cycle is still counted.
  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      rx_pkt_cnt_o  <= '0;
      rx_drop_cnt_o <= '0;
      rx_err_cnt_o  <= '0;
    end else if (err_clr_i) begin
      rx_pkt_cnt_o  <= {31'd0, push_ok};
      rx_drop_cnt_o <= {15'd0, set_ovf};
      rx_err_cnt_o  <= {15'd0, frame_err};
    end else begin
      if (push_ok) rx_pkt_cnt_o <= rx_pkt_cnt_o + 32'd1;
      if (set_ovf && (rx_drop_cnt_o != 16'hFFFF)) rx_drop_cnt_o <= rx_drop_cnt_o + 16'd1;
      if (frame_err && (rx_err_cnt_o != 16'hFFFF)) rx_err_cnt_o <= rx_err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tnet_rx_deframer.sv
// Self-checking bench for tnet_rx_deframer: table-driven framing cases plus scoreboarded FIFO sequences.
module tb_tnet_rx_deframer;

  logic        c_clk_i = 1'b0;
  logic        c_rst_i = 1'b1;
  logic        axi_rx_tvalid_i = 1'b0;
  logic [63:0] axi_rx_tdata_i = '0;
  logic        axi_rx_tlast_i = 1'b0;
  logic [7:0]  my_id_i = 8'h05;
  logic        pkt_vld_o;
  logic        pkt_rdy_i = 1'b0;
  logic [4:0]  pkt_op_o;
  logic [7:0]  pkt_dst_o;
  logic [7:0]  pkt_src_o;
  logic [7:0]  pkt_hop_o;
  logic [31:0] pkt_dt1_o;
  logic [31:0] pkt_dt2_o;
  logic [31:0] pkt_dt3_o;
  logic        pkt_mine_o;
  logic [3:0]  err_o;
  logic        err_clr_i = 1'b0;

  always #5 c_clk_i = ~c_clk_i;

  tnet_rx_deframer #(.FIFO_AW(2), .SYNC_MK(3'b101)) dut (
    .c_clk_i         (c_clk_i),
    .c_rst_i         (c_rst_i),
    .axi_rx_tvalid_i (axi_rx_tvalid_i),
    .axi_rx_tdata_i  (axi_rx_tdata_i),
    .axi_rx_tlast_i  (axi_rx_tlast_i),
    .my_id_i         (my_id_i),
    .pkt_vld_o       (pkt_vld_o),
    .pkt_rdy_i       (pkt_rdy_i),
    .pkt_op_o        (pkt_op_o),
    .pkt_dst_o       (pkt_dst_o),
    .pkt_src_o       (pkt_src_o),
    .pkt_hop_o       (pkt_hop_o),
    .pkt_dt1_o       (pkt_dt1_o),
    .pkt_dt2_o       (pkt_dt2_o),
    .pkt_dt3_o       (pkt_dt3_o),
    .pkt_mine_o      (pkt_mine_o),
    .err_o           (err_o),
    .err_clr_i       (err_clr_i)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [7:0]  hop;
    logic [31:0] dt1;
    logic [31:0] dt2;
    logic [31:0] dt3;
    logic        mine;
  } exp_pkt_t;

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] pay;
    int          nbeats;
    logic [7:0]  my_id;
    logic        clr;
    logic        exp_push;
    logic        exp_mine;
    logic [3:0]  exp_err;
  } vec_t;

  exp_pkt_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic exp_pkt_t model(input logic [63:0] hdr, input logic [63:0] pay, input logic mine);
    exp_pkt_t p;
    p.op   = hdr[60:56];
    p.dst  = hdr[55:48];
    p.src  = hdr[47:40];
    p.hop  = hdr[39:32];
    p.dt1  = hdr[31:0];
    p.dt2  = pay[63:32];
    p.dt3  = pay[31:0];
    p.mine = mine;
    return p;
  endfunction

  function automatic exp_pkt_t dut_pkt();
    return {pkt_op_o, pkt_dst_o, pkt_src_o, pkt_hop_o, pkt_dt1_o, pkt_dt2_o, pkt_dt3_o, pkt_mine_o};
  endfunction

  // Scoreboard: each accepted head packet must match the oldest expected packet.
  always @(negedge c_clk_i) begin
    if (!c_rst_i && pkt_vld_o === 1'b1 && pkt_rdy_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pkt: actual %0h required none", dut_pkt());
      end else begin
        checkOutput("pkt", dut_pkt(), sb_q.pop_front());
      end
    end
  end

  task automatic beat(input logic [63:0] d, input logic l);
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b1;
    axi_rx_tdata_i  = d;
    axi_rx_tlast_i  = l;
  endtask

  task automatic idle();
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b0;
    axi_rx_tdata_i  = '0;
    axi_rx_tlast_i  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] hdr, input logic [63:0] pay, input int nbeats);
    if (nbeats == 1) begin
      beat(hdr, 1'b1);
    end else if (nbeats == 2) begin
      beat(hdr, 1'b0);
      beat(pay, 1'b1);
    end else begin
      beat(hdr, 1'b0);
      beat(pay, 1'b0);
      beat(64'h5555_AAAA_5555_AAAA, 1'b1);
    end
  endtask

  task automatic clear_err();
    @(posedge c_clk_i); #1 err_clr_i = 1'b1;
    @(posedge c_clk_i); #1 err_clr_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge c_clk_i);
    checkOutput(name, sb_q.size(), 0);
    @(negedge c_clk_i);
    checkOutput({name, "_vld"}, pkt_vld_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t tbl[8];
  exp_pkt_t ep;
  logic [63:0] h;
  logic [63:0] p;

  initial begin
    tbl[0] = '{64'hA305_0200_1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 2, 8'h05, 1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[1] = '{64'hA305_0200_1234_5678, 64'h0,                   1, 8'h05, 1'b1, 1'b0, 1'b0, 4'b0001};
    tbl[2] = '{64'hA305_0200_0000_0001, 64'h1111_2222_3333_4444, 3, 8'h05, 1'b0, 1'b0, 1'b0, 4'b0011};
    tbl[3] = '{64'h0,                   64'h0,                   1, 8'h05, 1'b0, 1'b0, 1'b0, 4'b0111};
    tbl[4] = '{64'h6305_0200_0000_0000, 64'hDEAD_BEEF_CAFE_F00D, 2, 8'h05, 1'b1, 1'b0, 1'b0, 4'b0100};
    tbl[5] = '{64'hA1FF_0309_AABB_CCDD, 64'h0123_4567_89AB_CDEF, 2, 8'h05, 1'b1, 1'b1, 1'b1, 4'b0000};
    tbl[6] = '{64'hA407_0509_0000_0000, 64'hFFFF_FFFF_0000_0000, 2, 8'h05, 1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[7] = '{64'hBF12_3456_0000_0001, 64'h0000_0001_0000_0002, 2, 8'h12, 1'b1, 1'b1, 1'b1, 4'b0000};

    repeat (3) @(posedge c_clk_i);
    #1 c_rst_i = 1'b0;
    @(negedge c_clk_i);
    checkOutput("rst_vld", pkt_vld_o, 1'b0);
    checkOutput("rst_err", err_o, 4'b0000);
    checkOutput("rst_fields", dut_pkt(), '0);

    // Table-driven framing cases with the consumer always ready.
    pkt_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) clear_err();
      my_id_i = tbl[i].my_id;
      if (tbl[i].exp_push) sb_q.push_back(model(tbl[i].hdr, tbl[i].pay, tbl[i].exp_mine));
      applyStimulus(tbl[i].hdr, tbl[i].pay, tbl[i].nbeats);
      idle();
      drain($sformatf("vec%0d_drain", i));
      checkOutput($sformatf("vec%0d_err", i), err_o, tbl[i].exp_err);
    end

    // Latency and head hold: payload sampled at edge N, visible after edge N+1.
    my_id_i   = 8'h05;
    pkt_rdy_i = 1'b0;
    clear_err();
    ep = model(64'hA305_0200_1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    sb_q.push_back(ep);
    applyStimulus(64'hA305_0200_1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 2);
    idle();
    @(negedge c_clk_i);
    checkOutput("lat_edge_n", pkt_vld_o, 1'b0);
    @(negedge c_clk_i);
    checkOutput("lat_edge_n1", pkt_vld_o, 1'b1);
    checkOutput("head_first", dut_pkt(), ep);
    repeat (3) @(negedge c_clk_i);
    checkOutput("head_hold", dut_pkt(), ep);
    @(posedge c_clk_i); #1 pkt_rdy_i = 1'b1;
    drain("lat_drain");

    // Overflow: five back-to-back packets into a 4-deep FIFO with no consumer.
    pkt_rdy_i = 1'b0;
    clear_err();
    for (int k = 0; k < 5; k++) begin
      h = {8'hA3, 8'h05, 8'h02, 8'h00, 32'(k)};
      p = {32'hF00D_0000 + 32'(k), 32'hBEEF_0000 + 32'(k)};
      if (k < 4) sb_q.push_back(model(h, p, 1'b1));
      applyStimulus(h, p, 2);
    end
    idle();
    repeat (3) @(negedge c_clk_i);
    checkOutput("ovf_err", err_o, 4'b1000);
    checkOutput("ovf_head", dut_pkt(), sb_q[0]);
    @(posedge c_clk_i); #1 pkt_rdy_i = 1'b1;
    drain("ovf_drain");

    // Full FIFO with a pop on the exact push cycle of the fifth packet.
    pkt_rdy_i = 1'b0;
    clear_err();
    for (int k = 10; k < 15; k++) begin
      h = {8'hA3, 8'h05, 8'h02, 8'h00, 32'(k)};
      p = {32'h1234_0000 + 32'(k), 32'h5678_0000 + 32'(k)};
      sb_q.push_back(model(h, p, 1'b1));
      applyStimulus(h, p, 2);
    end
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b0;
    axi_rx_tlast_i  = 1'b0;
    pkt_rdy_i       = 1'b1;
    @(posedge c_clk_i); #1 pkt_rdy_i = 1'b0;
    repeat (2) @(negedge c_clk_i);
    checkOutput("fullpop_err", err_o, 4'b0000);
    checkOutput("fullpop_head", dut_pkt(), sb_q[0]);
    @(posedge c_clk_i); #1 pkt_rdy_i = 1'b1;
    drain("fullpop_drain");

    // Reset between header and payload.
    beat(64'hA305_0200_1234_5678, 1'b0);
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b0;
    c_rst_i         = 1'b1;
    @(posedge c_clk_i); #1 c_rst_i = 1'b0;
    beat(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    idle();
    @(negedge c_clk_i);
    checkOutput("midrst_err", err_o, 4'b0100);
    checkOutput("midrst_vld", pkt_vld_o, 1'b0);
    sb_q.push_back(model(64'hA302_0500_0000_00AA, 64'h0000_00BB_0000_00CC, 1'b0));
    applyStimulus(64'hA302_0500_0000_00AA, 64'h0000_00BB_0000_00CC, 2);
    idle();
    drain("midrst_drain");

    // Clear colliding with a short event: only the short bit survives.
    applyStimulus(64'h0, 64'h0, 1);
    applyStimulus(64'hA305_0200_0000_0000, 64'h0, 3);
    idle();
    @(negedge c_clk_i);
    checkOutput("coll_pre", err_o, 4'b0110);
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b1;
    axi_rx_tdata_i  = 64'hA305_0200_1234_5678;
    axi_rx_tlast_i  = 1'b1;
    err_clr_i       = 1'b1;
    @(posedge c_clk_i); #1;
    axi_rx_tvalid_i = 1'b0;
    axi_rx_tlast_i  = 1'b0;
    err_clr_i       = 1'b0;
    @(negedge c_clk_i);
    checkOutput("coll_err", err_o, 4'b0001);
    checkOutput("coll_vld", pkt_vld_o, 1'b0);

    repeat (2) @(negedge c_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
